// File: rtl/instr_dispatch.sv
// instr_dispatch: FIFO-buffered opcode decoder dispatching to EU/BIU/FCU via req/ack/done.
// Optional watchdog abort enabled by DISPATCH_TIMEOUT_EN.
module instr_dispatch #(
    parameter int IR_W    = 32,
    parameter int OPC_MSB = 21,
    parameter int DEPTH   = 4,
    parameter int TO_CYC  = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cs,
    input  logic [IR_W-1:0] ir,
    output logic            in_ready,
    output logic            cs_eu,
    output logic            cs_biu,
    output logic            cs_fcu,
    output logic [1:0]      sel_eu,
    output logic [1:0]      sel_biu,
    output logic            sel_fcu,
    input  logic            ready_eu,
    input  logic            ready_bus,
    input  logic            ready_fcu,
    output logic            done,
    output logic [2:0]      done_cls,
    output logic            err_illegal,
    output logic            err_timeout,
    output logic            busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] ILL = 3'd7;

    typedef enum logic [1:0] {IDLE, ISSUE, EXEC, RETIRE} state_t;

    function automatic logic [2:0] decode(input logic [5:0] op);
        return !op[5] ? 3'd0 : !op[4] ? 3'd1 : !op[3] ? 3'd2 :
               !op[2] ? 3'd3 : !op[1] ? 3'd4 : !op[0] ? 3'd5 : ILL;
    endfunction

    state_t      state;
    logic [2:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    logic [2:0]  cls, head;
    logic [1:0]  hd_sel_eu;
    logic        push, pop, rdy, is_biu, is_fcu, hd_eu, hd_biu, timeout;

    // FIFO stores the decoded class; only the opcode matters downstream
    assign in_ready  = count != (AW+1)'(DEPTH);
    assign push      = cs && in_ready;
    assign head      = mem[rptr];
    assign busy      = count != '0 || state != IDLE;
    assign hd_eu     = head == 3'd0 || head == 3'd4 || head == 3'd5;
    assign hd_biu    = head == 3'd1 || head == 3'd2;
    assign hd_sel_eu = head == 3'd4 ? 2'b01 : head == 3'd5 ? 2'b10 : 2'b00;
    assign is_fcu    = cls == 3'd3;
    assign is_biu    = cls == 3'd1 || cls == 3'd2;
    assign rdy       = is_fcu ? ready_fcu : is_biu ? ready_bus : ready_eu;
    assign pop       = (state == IDLE && count != '0 && head == ILL) || state == RETIRE || timeout;
    assign sel_fcu   = 1'b0;

    always_ff @(posedge clk)
        if (push) mem[wptr] <= decode(ir[OPC_MSB -: 6]);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);
    logic [TW-1:0] cnt;
    assign timeout = (state == ISSUE || state == EXEC) && cnt == TW'(TO_CYC);
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            cnt         <= (state == ISSUE || state == EXEC) ? cnt + TW'(1) : '0;
            err_timeout <= timeout;
        end
    end
`else
    assign timeout     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cls         <= '0;
            cs_eu       <= 1'b0;
            cs_biu      <= 1'b0;
            cs_fcu      <= 1'b0;
            sel_eu      <= '0;
            sel_biu     <= '0;
            done        <= 1'b0;
            done_cls    <= '0;
            err_illegal <= 1'b0;
        end else begin
            done        <= 1'b0;
            err_illegal <= 1'b0;
            case (state)
                IDLE: if (count != '0) begin
                    if (head == ILL) err_illegal <= 1'b1;
                    else begin
                        state   <= ISSUE;
                        cls     <= head;
                        cs_eu   <= hd_eu;
                        cs_biu  <= hd_biu;
                        cs_fcu  <= head == 3'd3;
                        sel_eu  <= hd_sel_eu;
                        sel_biu <= {1'b0, head == 3'd2};
                    end
                end
                ISSUE: if (!rdy) begin
                    state  <= EXEC;
                    cs_eu  <= 1'b0;
                    cs_biu <= 1'b0;
                    cs_fcu <= 1'b0;
                end
                EXEC: if (rdy) state <= RETIRE;
                RETIRE: begin
                    state    <= IDLE;
                    done     <= 1'b1;
                    done_cls <= cls;
                    sel_eu   <= '0;
                    sel_biu  <= '0;
                end
            endcase
            // watchdog abort overrides whatever the handshake was doing
            if (timeout) begin
                state   <= IDLE;
                cs_eu   <= 1'b0;
                cs_biu  <= 1'b0;
                cs_fcu  <= 1'b0;
                sel_eu  <= '0;
                sel_biu <= '0;
            end
        end
    end
endmodule

// File: tb/tb_instr_dispatch.sv
// tb_instr_dispatch: scoreboard bench for instr_dispatch with an auto-responding unit model.
module tb_instr_dispatch;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0] unit;
        logic [1:0] sel;
        logic [2:0] cls;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, cs = 1'b0;
    logic [31:0] ir = '0;
    logic ready_eu = 1'b1, ready_bus = 1'b1, ready_fcu = 1'b1;
    logic in_ready, cs_eu, cs_biu, cs_fcu, sel_fcu, done, err_illegal, err_timeout, busy;
    logic [1:0] sel_eu, sel_biu;
    logic [2:0] done_cls;

    instr_dispatch #(.IR_W(32), .OPC_MSB(21), .DEPTH(DEPTH), .TO_CYC(8)) dut (
        .clk(clk), .rst(rst), .cs(cs), .ir(ir), .in_ready(in_ready),
        .cs_eu(cs_eu), .cs_biu(cs_biu), .cs_fcu(cs_fcu),
        .sel_eu(sel_eu), .sel_biu(sel_biu), .sel_fcu(sel_fcu),
        .ready_eu(ready_eu), .ready_bus(ready_bus), .ready_fcu(ready_fcu),
        .done(done), .done_cls(done_cls), .err_illegal(err_illegal),
        .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, rise_cyc = 0;
    int dones = 0, ills = 0, timeouts = 0, accepted = 0;
    int mode_eu = 0, mode_bus = 0, mode_fcu = 0;
    bit chk_lat = 1'b1;
    exp_t q[$];
    exp_t e_m;
    logic [2:0] prev_cs = '0, csv;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] op);
        casez (op)
            6'b0?????: return '{2'd0, 2'b00, 3'd0};
            6'b10????: return '{2'd1, 2'b00, 3'd1};
            6'b110???: return '{2'd1, 2'b01, 3'd2};
            6'b1110??: return '{2'd2, 2'b00, 3'd3};
            6'b11110?: return '{2'd0, 2'b01, 3'd4};
            6'b111110: return '{2'd0, 2'b10, 3'd5};
            default:   return '{2'd3, 2'b00, 3'd0};
        endcase
    endfunction

    // unit model: mode 0 accepts immediately and finishes next cycle, 1 holds ready low, 2 holds high
    initial forever begin
        @(negedge clk);
        ready_eu  = mode_eu == 2 || (mode_eu == 0 && !cs_eu);
        ready_bus = mode_bus == 2 || (mode_bus == 0 && !cs_biu);
        ready_fcu = mode_fcu == 2 || (mode_fcu == 0 && !cs_fcu);
    end

    always @(negedge clk) begin
        if (rst) prev_cs = '0;
        else begin
            if (done) begin
                dones++;
                if (q.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    e_m = q.pop_front();
                    chk("done_cls", done_cls, e_m.cls);
                    if (chk_lat) chk("done_latency", cyc - rise_cyc, 3);
                end
            end
            if (err_illegal) begin
                ills++;
                if (q.size() == 0) chk("illegal_unexpected", 1, 0);
                else begin
                    e_m = q.pop_front();
                    chk("illegal_unit", e_m.unit, 3);
                end
            end
            if (err_timeout) begin
                timeouts++;
                if (q.size() == 0) chk("timeout_unexpected", 1, 0);
                else begin
                    e_m = q.pop_front();
                    chk("timeout_unit", e_m.unit, 1);
                end
            end
            csv = {cs_fcu, cs_biu, cs_eu};
            if (csv != 0) begin
                chk("cs_onehot", $countones(csv), 1);
                chk("sel_nontarget", {cs_eu ? 2'b00 : sel_eu, cs_biu ? 2'b00 : sel_biu, cs_fcu ? 1'b0 : sel_fcu}, 0);
            end
            if (csv != 0 && prev_cs == 0) begin
                rise_cyc = cyc;
                if (q.size() == 0) chk("cs_unexpected", 1, 0);
                else begin
                    chk("cs_unit", cs_eu ? 0 : cs_biu ? 1 : 2, q[0].unit);
                    chk("cs_sel", cs_eu ? sel_eu : cs_biu ? sel_biu : {1'b0, sel_fcu}, q[0].sel);
                end
            end
            prev_cs = csv;
        end
    end

    task automatic push_op(input logic [5:0] op);
        ir = $urandom;
        ir[21:16] = op;
        cs = 1'b1;
        if (in_ready) begin
            q.push_back(model(op));
            accepted++;
        end
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_bound", n < 300, 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask

    int d0, a0, i0, t0, n;
    logic [5:0] op;
    logic [5:0] full_ops [5] = '{6'b000000, 6'b111100, 6'b111110, 6'b011111, 6'b000001};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cs", {cs_eu, cs_biu, cs_fcu}, 0);
        chk("rst_sel", {sel_eu, sel_biu, sel_fcu}, 0);
        chk("rst_done", {done, done_cls}, 0);
        chk("rst_err", {err_illegal, err_timeout}, 0);
        rst = 1'b0;
        @(negedge clk);

        push_op(6'b000000);
        chk("arith_i_cs_pre", cs_eu, 0);
        @(negedge clk);
        chk("arith_i_cs_eu", cs_eu, 1);
        chk("arith_i_sel", sel_eu, 0);
        @(negedge clk);
        chk("arith_i_cs_one_cycle", cs_eu, 0);
        wait_idle();

        d0 = dones;
        push_op(6'b100101);
        push_op(6'b110010);
        push_op(6'b111001);
        wait_idle();
        chk("biu_fcu_dones", dones - d0, 3);

        mode_eu = 1;
        chk_lat = 1'b0;
        a0 = accepted;
        d0 = dones;
        for (int i = 0; i < DEPTH + 1; i++) push_op(full_ops[i]);
        chk("full_in_ready", in_ready, 0);
        chk("full_accepted", accepted - a0, DEPTH);
        chk("full_queue", q.size(), DEPTH);
        repeat (5) @(negedge clk);
        mode_eu = 0;
        wait_idle();
        chk_lat = 1'b1;
        chk("full_dones", dones - d0, DEPTH);

        i0 = ills;
        push_op(6'b111111);
        push_op(6'b111110);
        wait_idle();
        chk("illegal_count", ills - i0, 1);

        mode_eu = 1;
        for (int i = 0; i < 3; i++) push_op(6'b000010);
        repeat (3) @(negedge clk);
        chk("midreset_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_cs", {cs_eu, cs_biu, cs_fcu}, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_in_ready", in_ready, 1);
        rst = 1'b0;
        q.delete();
        mode_eu = 0;
        d0 = dones;
        repeat (12) @(negedge clk);
        chk("midreset_no_done", dones - d0, 0);
        chk("midreset_idle", busy, 0);

        d0 = dones;
        a0 = accepted;
        i0 = ills;
        for (int i = 0; i < 16; i++) begin
            op = $urandom;
            if ($urandom_range(0, 4) == 0) op = 6'h3f;
            push_op(op);
        end
        wait_idle();
        chk("random_retired", (dones - d0) + (ills - i0), accepted - a0);

        mode_bus = 2;
        t0 = timeouts;
        push_op(6'b100000);
`ifdef DISPATCH_TIMEOUT_EN
        n = 0;
        while (timeouts == t0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_seen", timeouts - t0, 1);
        @(negedge clk);
        chk("timeout_idle", busy, 0);
        chk("timeout_cs", cs_biu, 0);
`else
        repeat (30) @(negedge clk);
        chk("hang_cs_biu", cs_biu, 1);
        chk("hang_no_timeout", timeouts - t0, 0);
        chk("hang_busy", busy, 1);
        pulse_reset();
`endif
        mode_bus = 0;
        repeat (3) @(negedge clk);
        chk("end_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
